// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : lsu_ctrl_if                                                  |
// | Brief  : Pipeline and data-memory signal bundle for lsu_ctrl          |
// | Rev    : 1.0                                                          |
// +----------------------------------------------------------------------+
interface lsu_ctrl_if #(
  parameter int N = 32,
  parameter int K = 512
);
  localparam int c_AW = $clog2(K);

  logic            Req;
  logic            ReqWe;
  logic [31:0]     ReqAddr;
  logic [N-1:0]    ReqData;
  logic [1:0]      ReqSize;
  logic            ReqSigned;
  logic            Busy;
  logic            Done;
  logic [N-1:0]    RdData;
  logic            Fault;
  logic [c_AW-1:0] MemAddr;
  logic [N-1:0]    MemVin;
  logic            MemEn;
  logic            MemRw;
  logic            MemSigExt;
  logic [1:0]      MemBHW;
  logic [N-1:0]    MemVout;
  logic            MemAck;

  // master = pipeline + memory environment, slave = the controller
  modport master (
    output Req, ReqWe, ReqAddr, ReqData, ReqSize, ReqSigned, MemVout, MemAck,
    input  Busy, Done, RdData, Fault, MemAddr, MemVin, MemEn, MemRw, MemSigExt, MemBHW
  );
  modport slave (
    input  Req, ReqWe, ReqAddr, ReqData, ReqSize, ReqSigned, MemVout, MemAck,
    output Busy, Done, RdData, Fault, MemAddr, MemVin, MemEn, MemRw, MemSigExt, MemBHW
  );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : lsu_ctrl                                                     |
// | Brief  : Load/store unit controller, byte/half via read-modify-write  |
// | Rev    : 1.0                                                          |
// +----------------------------------------------------------------------+
module lsu_ctrl #(
  parameter int N   = 32,
  parameter int K   = 512,
  parameter int TMO = 15
) (
  input  wire logic     Clk,
  input  wire logic     Rst,
  lsu_ctrl_if.slave     bus
);
  localparam int c_AW = $clog2(K);
  localparam int c_WW = $clog2(TMO + 1);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_RD    = 3'd1;
  localparam logic [2:0] c_S_WR    = 3'd2;
  localparam logic [2:0] c_S_DONE  = 3'd3;
  localparam logic [2:0] c_S_FAULT = 3'd4;

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic            r_we;
  logic [c_AW+1:0] r_addr;
  logic [N-1:0]    r_data;
  logic [1:0]      r_size;
  logic            r_signed;
  logic [N-1:0]    r_buf;
  logic [N-1:0]    r_rd;
  logic [c_WW-1:0] r_wdog;

  logic            w_accepting;
  logic            w_ack;
  logic            w_bad;
  logic            w_tmo;
  logic            w_busy;
  logic [N-1:0]    w_merged;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [N-1:0]    w_load;

  assign w_accepting = (r_state == c_S_IDLE) || (r_state == c_S_DONE) || (r_state == c_S_FAULT);
  assign w_busy      = (r_state == c_S_RD) || (r_state == c_S_WR);
  // Only a clean logic 1 acknowledges; X/Z from the memory side never does
  assign w_ack       = (bus.MemAck === 1'b1);
  assign w_tmo       = !w_ack && (r_wdog == c_WW'(TMO - 1));
  assign w_bad       = (bus.ReqSize == 2'b11)
                    || ((bus.ReqSize == 2'b01) && bus.ReqAddr[0])
                    || ((bus.ReqSize == 2'b10) && (bus.ReqAddr[1:0] != 2'b00))
                    || (bus.ReqAddr >= 32'(4 * K));

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= c_S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE, c_S_DONE, c_S_FAULT: begin
        if (!bus.Req)                                w_next = c_S_IDLE;
        else if (w_bad)                              w_next = c_S_FAULT;
        else if (bus.ReqWe && bus.ReqSize == 2'b10)  w_next = c_S_WR;
        else                                         w_next = c_S_RD;
      end
      c_S_RD: begin
        if (w_ack)      w_next = r_we ? c_S_WR : c_S_DONE;
        else if (w_tmo) w_next = c_S_FAULT;
      end
      c_S_WR: begin
        if (w_ack)      w_next = c_S_DONE;
        else if (w_tmo) w_next = c_S_FAULT;
      end
      default: w_next = c_S_IDLE;
    endcase
  end

  // Store merge: buffered word with only the addressed lane replaced
  always_comb begin
    w_merged = r_buf;
    case (r_size)
      2'b00:   w_merged[{r_addr[1:0], 3'b000} +: 8]  = r_data[7:0];
      2'b01:   w_merged[{r_addr[1], 4'b0000} +: 16]  = r_data[15:0];
      default: w_merged = r_data;
    endcase
  end

  assign w_byte = bus.MemVout[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = bus.MemVout[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (r_size)
      2'b00:   w_load = {{(N-8){r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{(N-16){r_signed & w_half[15]}}, w_half};
      default: w_load = bus.MemVout;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_buf    <= '0;
      r_rd     <= '0;
      r_wdog   <= '0;
    end else begin
      if (w_accepting && bus.Req) begin
        r_we     <= bus.ReqWe;
        r_addr   <= bus.ReqAddr[c_AW+1:0];
        r_data   <= bus.ReqData;
        r_size   <= bus.ReqSize;
        r_signed <= bus.ReqSigned;
      end
      // Watchdog restarts on every entry into a memory-access state
      if ((r_state != w_next) && ((w_next == c_S_RD) || (w_next == c_S_WR)))
        r_wdog <= '0;
      else if (w_busy && !w_ack)
        r_wdog <= r_wdog + 1'b1;
      if (r_state == c_S_RD && w_ack) begin
        r_buf <= bus.MemVout;
        if (!r_we) r_rd <= w_load;
      end
    end
  end

  always_comb begin
    bus.Busy      = w_busy;
    bus.Done      = (r_state == c_S_DONE);
    bus.Fault     = (r_state == c_S_FAULT);
    bus.MemEn     = w_busy;
    bus.MemRw     = (r_state == c_S_WR);
    bus.MemVin    = (r_state == c_S_WR) ? w_merged : '0;
    bus.MemAddr   = r_addr[c_AW+1:2];
    bus.RdData    = r_rd;
    bus.MemSigExt = 1'b0;
    bus.MemBHW    = 2'b10;
  end
endmodule
`default_nettype wire
